// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in tick units and
// publishes a new measurement on every rising edge of the line.
//
//   state | meaning
//   IDLE  | no measurement running; waiting for a rising edge
//   HIGH  | inside the high phase of a period being measured
//   LOW   | inside the low phase; the next rise closes the period
module pwm_capture #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            tick,
  input  logic            pwm_in,
  output logic [BITS-1:0] high_count,
  output logic [BITS-1:0] period_count,
  output logic            valid,
  output logic            ovf,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            pwm_s_q, pwm_s_d;
  logic            prev_q, prev_d;
  logic [BITS-1:0] hcnt_q, hcnt_d;
  logic [BITS-1:0] pcnt_q, pcnt_d;
  logic [BITS-1:0] high_count_q, high_count_d;
  logic [BITS-1:0] period_count_q, period_count_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

  logic            s;
  logic            rise;
  logic            pcnt_full;

  assign s         = pwm_s_q;
  assign rise      = s & ~prev_q;
  assign pcnt_full = &pcnt_q;

  always_comb begin
    state_d        = state_q;
    sync1_d        = pwm_in;
    pwm_s_d        = sync1_q;
    prev_d         = prev_q;
    hcnt_d         = hcnt_q;
    pcnt_d         = pcnt_q;
    high_count_d   = high_count_q;
    period_count_d = period_count_q;
    valid_d        = 1'b0;
    ovf_d          = 1'b0;

    // Edge history follows the line even while disabled, so re-enabling
    // on a high line does not look like a fresh rise.
    if (tick) begin
      prev_d = s;
    end

    if (!enable) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            hcnt_d  = CNT_ONE;
            pcnt_d  = CNT_ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (pcnt_full) begin
            ovf_d   = 1'b1;
            hcnt_d  = '0;
            pcnt_d  = '0;
            state_d = IDLE;
          end else if (s) begin
            hcnt_d = hcnt_q + CNT_ONE;
            pcnt_d = pcnt_q + CNT_ONE;
          end else begin
            pcnt_d  = pcnt_q + CNT_ONE;
            state_d = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            high_count_d   = hcnt_q;
            period_count_d = pcnt_q;
            valid_d        = 1'b1;
            hcnt_d         = CNT_ONE;
            pcnt_d         = CNT_ONE;
            state_d        = HIGH;
          end else if (pcnt_full) begin
            ovf_d   = 1'b1;
            hcnt_d  = '0;
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b0;
      pwm_s_q        <= 1'b0;
      prev_q         <= 1'b0;
      hcnt_q         <= '0;
      pcnt_q         <= '0;
      high_count_q   <= '0;
      period_count_q <= '0;
      valid_q        <= 1'b0;
      ovf_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      pwm_s_q        <= pwm_s_d;
      prev_q         <= prev_d;
      hcnt_q         <= hcnt_d;
      pcnt_q         <= pcnt_d;
      high_count_q   <= high_count_d;
      period_count_q <= period_count_d;
      valid_q        <= valid_d;
      ovf_q          <= ovf_d;
      busy_q         <= busy_d;
    end
  end

  assign high_count   = high_count_q;
  assign period_count = period_count_q;
  assign valid        = valid_q;
  assign ovf          = ovf_q;
  assign busy         = busy_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: high time and period, in units of sample ticks. It is the receive-side counterpart of the PWM generator and is used to loop back or monitor a PWM line. The sample rate comes from a `tick` strobe, normally driven by the generic `Timer` prescaler. A new measurement is published once per PWM period, on each rising edge.

## Interface
- `BITS`, default 8: width of the internal counters and the measurement outputs. The maximum measurable period is 2^BITS-1 ticks.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `enable`  in  1  measurement enable; low forces idle.
- `tick`  in  1  sample strobe, one `clk` wide; all measurement activity happens only on `tick`=1 cycles.
- `pwm_in`  in  1  external PWM line, asynchronous to `clk`.
- `high_count`  out  BITS  high time of the last complete period, in ticks.
- `period_count`  out  BITS  length of the last complete period, in ticks.
- `valid`  out  1  one-`clk` pulse when `high_count`/`period_count` update.
- `ovf`  out  1  one-`clk` pulse when a measurement is aborted because a counter would exceed 2^BITS-1.
- `busy`  out  1  high while the FSM is not IDLE.

## Operation
- **Synchronizer.** `pwm_in` passes through a 2-flop synchronizer, both flops reset to 0, giving `pwm_s`.
- **Sample and edge.** On each `tick` cycle, sample `s = pwm_s`. Register `prev` is updated with `s` on every tick, regardless of `enable`, and resets to 0. `rise = s & ~prev`.
- **Counters.** `hcnt` and `pcnt` are BITS wide and reset to 0.
- **FSM.** States are IDLE, HIGH and LOW; reset state is IDLE. Transitions are evaluated only on `tick` cycles.
  - IDLE: if `rise`, set `hcnt`=1 and `pcnt`=1, then go to HIGH.
  - HIGH, `s`=1:
    - if `pcnt` is all-ones: `ovf`, clear both counters, go to IDLE.
    - otherwise: increment `hcnt` and `pcnt`.
  - HIGH, `s`=0:
    - if `pcnt` is all-ones: `ovf`, go to IDLE.
    - otherwise: increment `pcnt`, go to LOW.
  - LOW, `rise`:
    - copy `hcnt` to `high_count` and `pcnt` to `period_count`, and pulse `valid`.
    - set `hcnt`=1 and `pcnt`=1, go to HIGH. No period is lost between measurements.
  - LOW, no rise:
    - if `pcnt` is all-ones: `ovf`, go to IDLE.
    - otherwise: increment `pcnt`.
- **Width rule.** Counters never wrap. Overflow always aborts the measurement.
  - A period of exactly 2^BITS-1 ticks is reported.
  - A period of 2^BITS ticks or more gives `ovf`.
- **Stuck line.** 0% or 100% duty gives `ovf` after at most 2^BITS ticks in the measuring states. The FSM then waits in IDLE for the next rise.
- **Enable.** While `enable`=0:
  - the FSM is forced to IDLE and `hcnt`/`pcnt` are cleared;
  - `valid` and `ovf` stay 0;
  - `high_count`/`period_count` hold their last values.
- **Re-enable.** After `enable` returns to 1, the first `valid` needs a full period starting at a fresh `rise`. The `prev` tracking prevents a false edge at re-enable.
- **Outputs on abort.** `high_count`/`period_count` change only together with `valid`. `ovf` leaves them untouched.
- **Ticks.** Non-tick cycles change nothing except the synchronizer flops. A `tick` held high continuously means one sample per `clk`.

## Timing
- **Reset values.** `high_count`=0, `period_count`=0, `valid`=0, `ovf`=0, `busy`=0, FSM in IDLE.
- **Input latency.** From a `pwm_in` change to `pwm_s`: 2 `clk` cycles. Sampling then waits for the next `tick`.
- **Output timing.** `valid`, `ovf`, `high_count`, `period_count` and `busy` are registered. They change in the `clk` cycle after the tick cycle that caused the event. `valid` and `ovf` are exactly one `clk` wide.
- **Mutual exclusion.** `valid` and `ovf` are never high in the same cycle.
- **Reset mid-measurement.** Reset clears everything immediately and asynchronously. No `valid` or `ovf` is produced for the interrupted period.
- **Enable priority.** `enable`=0 on a tick cycle takes priority over any transition on that tick.

## Test plan
- **Basic 3/5.** `tick`=1, BITS=8, `pwm_in` repeating 3 high / 5 low clk.
  - Expect `valid` pulses exactly every 8 clk, each with `high_count`=3 and `period_count`=8.
  - The first `valid` comes one full period after the first observed rise.
- **Prescaled tick.** `tick` every 4th clk, from a Timer with Final_Value=3; `pwm_in` 8 high / 8 low clk, edges aligned just before ticks.
  - Expect `high_count`=2, `period_count`=4, and `valid` every 16 clk.
- **Minimum and maximum period.**
  - `tick`=1, 1 high / 1 low: expect `high_count`=1, `period_count`=2.
  - 1 high / 254 low: expect `period_count`=255 with no `ovf`.
  - 1 high / 255 low: expect `ovf` with no `valid`, and outputs keep their prior values.
- **Stuck high.**
  - `tick`=1, `pwm_in` rises and stays 1: `ovf` occurs on the 255th tick after the rise. `busy` falls with it, and no `valid` is produced.
  - A later low-then-high resumes measurement.
- **Reset mid-measurement.** Assert `reset` low in HIGH state.
  - All outputs go to 0 immediately.
  - After release with a 3/5 waveform, the first `valid` reports 3/8 and never a partial period.
- **Enable toggle.** Drop `enable` for 2 clk in the middle of a LOW phase.
  - No `valid` is produced for that period, and `high_count`/`period_count` hold.
  - The next complete period after re-enable reports correctly.
